// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract responder.
// Op encodings, response record width and queue occupancy states.
package addsub_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int DATA_W = 8;
  // sum, cout, ovf, zero
  localparam int RSP_W = DATA_W + 3;
  typedef enum logic [1:0] {
    Q_EMPTY,
    Q_PARTIAL,
    Q_FULL
  } q_state_t;
endpackage

// File: rtl/addsub_rsp_fifo.sv
// In-order response queue, DEPTH x W, synchronous active-high reset.
// Ports: clk, rst, push/din, pop/dout, count, full, empty.
module addsub_rsp_fifo
  import addsub_pkg::*;
#(
  parameter int W = RSP_W,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  q_state_t      state;

  always_comb begin
    state = Q_EMPTY;
    if (count == CNT_FULL)
      state = Q_FULL;
    else if (count != '0)
      state = Q_PARTIAL;
  end

  assign empty   = (state == Q_EMPTY);
  assign full    = (state == Q_FULL);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of 2, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/addsub_responder.sv
// Valid/ready responder around an 8-bit add/subtract core.
// Ports: req_* in (valid/ready), rsp_* out (valid/ready), op_count.
module addsub_responder
  import addsub_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  input  logic             req_addsub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic [CNTW-1:0]  op_count
);
  localparam int RW = WIDTH + 3;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] b_x;
  logic             c_x;
  logic [WIDTH:0]   raw;
  logic             ovf;
  logic             zero;
  logic [RW-1:0]    rec;
  logic [RW-1:0]    head;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             accept;
  logic             pop;

  // sub is a + ~b + ~cin, i.e. a - b - cin
  assign b_x = (req_addsub == OP_SUB) ? ~req_b : req_b;
  assign c_x = (req_addsub == OP_SUB) ? ~req_cin : req_cin;
  assign raw = {1'b0, req_a} + {1'b0, b_x}
             + {{WIDTH{1'b0}}, c_x};

  assign ovf  = (req_a[WIDTH-1] == b_x[WIDTH-1])
             && (raw[WIDTH-1] != req_a[WIDTH-1]);
  assign zero = (raw[WIDTH-1:0] == '0);
  assign rec  = {raw[WIDTH-1:0], raw[WIDTH], ovf, zero};

  // ready comes from registered occupancy only
  assign req_ready = (count < CW'(DEPTH));
  assign accept    = req_valid && req_ready && !full;
  assign rsp_valid = !empty;
  assign pop       = rsp_valid && rsp_ready;

  assign {rsp_sum, rsp_cout, rsp_ovf, rsp_zero} = head;

  addsub_rsp_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (rec),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst)
      op_count <= '0;
    else if (accept)
      op_count <= op_count + 1'b1;
  end
endmodule

// File: tb/tb_addsub_responder.sv
// Scoreboard bench for addsub_responder.
// Directed vectors; monitor pops expected records on each handshake.
module tb_addsub_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_a = '0;
  logic [7:0]  req_b = '0;
  logic        req_cin = 1'b0;
  logic        req_addsub = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_sum;
  logic        rsp_cout;
  logic        rsp_ovf;
  logic        rsp_zero;
  logic [15:0] op_count;

  int total = 0;
  int bad = 0;
  logic [10:0] sb[$];

  always #5 clk = ~clk;

  addsub_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .req_addsub (req_addsub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf),
    .rsp_zero   (rsp_zero),
    .op_count   (op_count)
  );

  // inputs change on negedge; sample 1ns later
  always @(negedge clk) begin
    logic [10:0] got;
    logic [10:0] e;
    #1;
    got = {rsp_sum, rsp_cout, rsp_ovf, rsp_zero};
    if (!rst && rsp_valid && rsp_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp got=%h", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL rsp got=%h exp=%h", got, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accept
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic op,
                      input logic [10:0] e);
    int n;
    req_a = a;
    req_b = b;
    req_cin = cin;
    req_addsub = op;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=0 exp=1");
    end else begin
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_opcnt", op_count, 0);
    chk("rst_fields", {rsp_sum, rsp_cout, rsp_ovf, rsp_zero}, 0);

    rsp_ready = 1'b1;
    send(8'hFF, 8'h01, 0, 0, {8'h00, 1'b1, 1'b0, 1'b1});
    chk("lat_valid", rsp_valid, 1);
    chk("opcnt1", op_count, 1);
    send(8'h7F, 8'h01, 0, 0, {8'h80, 1'b0, 1'b1, 1'b0});
    chk("opcnt2", op_count, 2);
    send(8'h05, 8'h03, 0, 1, {8'h02, 1'b1, 1'b0, 1'b0});
    send(8'h03, 8'h05, 0, 1, {8'hFE, 1'b0, 1'b0, 1'b0});
    send(8'h80, 8'h01, 0, 1, {8'h7F, 1'b1, 1'b1, 1'b0});
    send(8'h10, 8'h20, 1, 0, {8'h31, 1'b0, 1'b0, 1'b0});
    send(8'h05, 8'h03, 1, 1, {8'h01, 1'b1, 1'b0, 1'b0});
    send(8'h80, 8'h80, 0, 0, {8'h00, 1'b1, 1'b1, 1'b1});
    drain();
    chk("opcnt8", op_count, 8);

    // backpressure: fill, stall a third, then full+pop
    rsp_ready = 1'b0;
    send(8'h00, 8'h01, 0, 1, {8'hFF, 1'b0, 1'b0, 1'b0});
    send(8'h40, 8'h40, 0, 0, {8'h80, 1'b0, 1'b1, 1'b0});
    chk("full_ready", req_ready, 0);
    chk("opcnt10", op_count, 10);
    req_a = 8'h01;
    req_b = 8'h02;
    req_cin = 1'b1;
    req_addsub = 1'b0;
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_opcnt", op_count, 10);
    chk("stall_ready", req_ready, 0);
    chk("stall_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("fullpop_noacc", op_count, 10);
    chk("fullpop_ready", req_ready, 1);
    sb.push_back({8'h04, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("opcnt11", op_count, 11);
    drain();

    // reset with two queued responses
    rsp_ready = 1'b0;
    send(8'h01, 8'h01, 0, 0, {8'h02, 1'b0, 1'b0, 1'b0});
    send(8'h02, 8'h02, 0, 0, {8'h04, 1'b0, 1'b0, 1'b0});
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("mrst_valid", rsp_valid, 0);
    chk("mrst_opcnt", op_count, 0);
    chk("mrst_ready", req_ready, 1);
    rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_stale", rsp_valid, 0);
    send(8'h10, 8'h10, 0, 1, {8'h00, 1'b1, 1'b0, 1'b1});
    chk("post_opcnt", op_count, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
